// File: rtl/stack_ctrl.sv
// stack_ctrl: pointer/sequencing controller for the 2R1W data stack RAM.
//
// The RAM is asynchronous-read / synchronous-write. Both read ports are driven
// continuously from the stack pointer, so TOS and NOS are always visible
// combinationally. One stack op is accepted per handshake. SWAP needs two
// writes and therefore occupies two cycles. An op that would overflow or
// underflow is still consumed but has no effect. It sets a sticky error flag.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   op_valid/op/op_data        op request: opcode and 16-bit operand
//   op_ready                   op accepted this cycle when op_valid is also high
//   tos, nos                   top / next-of-stack (gated to 0 when the slot is unused)
//   depth, empty, full         occupancy
//   err_ovf, err_unf, err_clr  sticky error flags and their clear
//   mem_rd_addr0/1, mem_rdata0/1         RAM read ports (TOS / NOS slots)
//   mem_we, mem_wr_addr, mem_wdata       RAM write port
module stack_ctrl #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned SIZE  = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [15:0]      op_data,
   output logic             op_ready,
   output logic [15:0]      tos,
   output logic [15:0]      nos,
   output logic [WIDTH:0]   depth,
   output logic             empty,
   output logic             full,
   output logic             err_ovf,
   output logic             err_unf,
   input  logic             err_clr,
   output logic [WIDTH-1:0] mem_rd_addr0,
   output logic [WIDTH-1:0] mem_rd_addr1,
   input  logic [15:0]      mem_rdata0,
   input  logic [15:0]      mem_rdata1,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_wr_addr,
   output logic [15:0]      mem_wdata
);

   localparam logic [2:0] OpNop      = 3'd0;
   localparam logic [2:0] OpPush     = 3'd1;
   localparam logic [2:0] OpPop      = 3'd2;
   localparam logic [2:0] OpPop2Push = 3'd3;
   localparam logic [2:0] OpDup      = 3'd4;
   localparam logic [2:0] OpSwap     = 3'd5;
   localparam logic [2:0] OpOver     = 3'd6;
   localparam logic [2:0] OpReplace  = 3'd7;

   typedef enum logic [0:0] {StIdle, StSwap2} state_e;

   state_e            state_q, state_d;
   logic [WIDTH:0]    sp_q, sp_d;
   logic [15:0]       hold_q, hold_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_unf_q, err_unf_d;

   logic              accept;
   logic              has1, has2, is_full;
   logic              set_ovf, set_unf;
   logic [WIDTH-1:0]  sp_lo, addr_tos, addr_nos;

   // Slot addresses wrap mod SIZE. When a slot is unused its value is
   // don't-care because tos/nos are gated below.
   assign sp_lo    = sp_q[WIDTH-1:0];
   assign addr_tos = sp_lo - WIDTH'(1);
   assign addr_nos = sp_lo - WIDTH'(2);

   assign has1    = (sp_q != '0);
   assign has2    = (sp_q >= (WIDTH+1)'(2));
   assign is_full = (sp_q == (WIDTH+1)'(SIZE));

   assign op_ready = (state_q == StIdle);
   assign accept   = op_valid & op_ready;

   assign mem_rd_addr0 = addr_tos;
   assign mem_rd_addr1 = addr_nos;
   assign tos          = has1 ? mem_rdata0 : 16'h0000;
   assign nos          = has2 ? mem_rdata1 : 16'h0000;

   assign depth   = sp_q;
   assign empty   = ~has1;
   assign full    = is_full;
   assign err_ovf = err_ovf_q;
   assign err_unf = err_unf_q;

   always_comb begin
      sp_d        = sp_q;
      state_d     = state_q;
      hold_d      = hold_q;
      mem_we      = 1'b0;
      mem_wr_addr = sp_lo;
      mem_wdata   = op_data;
      set_ovf     = 1'b0;
      set_unf     = 1'b0;

      unique case (state_q)
         StSwap2: begin
            // Second half of SWAP: old TOS goes into the NOS slot.
            mem_we      = 1'b1;
            mem_wr_addr = addr_nos;
            mem_wdata   = hold_q;
            state_d     = StIdle;
         end
         default: begin
            if (accept) begin
               case (op)
                  OpPush: begin
                     if (is_full) begin
                        set_ovf = 1'b1;
                     end else begin
                        mem_we      = 1'b1;
                        mem_wr_addr = sp_lo;
                        mem_wdata   = op_data;
                        sp_d        = sp_q + 1'b1;
                     end
                  end
                  OpPop: begin
                     if (!has1) set_unf = 1'b1;
                     else       sp_d    = sp_q - 1'b1;
                  end
                  OpPop2Push: begin
                     if (!has2) begin
                        set_unf = 1'b1;
                     end else begin
                        mem_we      = 1'b1;
                        mem_wr_addr = addr_nos;
                        mem_wdata   = op_data;
                        sp_d        = sp_q - 1'b1;
                     end
                  end
                  OpDup: begin
                     if (is_full) begin
                        set_ovf = 1'b1;
                     end else if (!has1) begin
                        set_unf = 1'b1;
                     end else begin
                        mem_we      = 1'b1;
                        mem_wr_addr = sp_lo;
                        mem_wdata   = tos;
                        sp_d        = sp_q + 1'b1;
                     end
                  end
                  OpOver: begin
                     if (is_full) begin
                        set_ovf = 1'b1;
                     end else if (!has2) begin
                        set_unf = 1'b1;
                     end else begin
                        mem_we      = 1'b1;
                        mem_wr_addr = sp_lo;
                        mem_wdata   = nos;
                        sp_d        = sp_q + 1'b1;
                     end
                  end
                  OpReplace: begin
                     if (!has1) begin
                        set_unf = 1'b1;
                     end else begin
                        mem_we      = 1'b1;
                        mem_wr_addr = addr_tos;
                        mem_wdata   = op_data;
                     end
                  end
                  OpSwap: begin
                     if (!has2) begin
                        set_unf = 1'b1;
                     end else begin
                        // First half: NOS into the TOS slot, park old TOS.
                        mem_we      = 1'b1;
                        mem_wr_addr = addr_tos;
                        mem_wdata   = nos;
                        hold_d      = tos;
                        state_d     = StSwap2;
                     end
                  end
                  OpNop: ;
                  default: ;
               endcase
            end
         end
      endcase

      // Set takes priority over a simultaneous clear.
      err_ovf_d = (err_ovf_q & ~err_clr) | set_ovf;
      err_unf_d = (err_unf_q & ~err_clr) | set_unf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sp_q      <= '0;
         hold_q    <= 16'h0000;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sp_q      <= sp_d;
         hold_q    <= hold_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

   localparam int unsigned WIDTH = 6;
   localparam int unsigned SIZE  = 64;

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, POP2PUSH = 3'd3;
   localparam logic [2:0] DUP = 3'd4, SWAP = 3'd5, OVER = 3'd6, REPLACE = 3'd7;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             op_valid = 1'b0;
   logic [2:0]       op = NOP;
   logic [15:0]      op_data = 16'h0;
   logic             op_ready;
   logic [15:0]      tos, nos;
   logic [WIDTH:0]   depth;
   logic             empty, full, err_ovf, err_unf;
   logic             err_clr = 1'b0;
   logic [WIDTH-1:0] mem_rd_addr0, mem_rd_addr1, mem_wr_addr;
   logic [15:0]      mem_rdata0, mem_rdata1, mem_wdata;
   logic             mem_we;

   int tests  = 0;
   int fails  = 0;
   int we_cnt = 0;
   int we0;

   logic [15:0] ram [SIZE];

   always #5 clk = ~clk;

   // Behavioural 2R1W RAM: async read, sync write.
   assign mem_rdata0 = ram[mem_rd_addr0];
   assign mem_rdata1 = ram[mem_rd_addr1];
   always @(posedge clk) if (mem_we) ram[mem_wr_addr] <= mem_wdata;

   // Inputs change just after posedge, so mid-cycle is a stable sampling point.
   always @(negedge clk) if (mem_we) we_cnt++;

   stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op(op), .op_data(op_data), .op_ready(op_ready),
      .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full),
      .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr),
      .mem_rd_addr0(mem_rd_addr0), .mem_rd_addr1(mem_rd_addr1),
      .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1),
      .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wdata(mem_wdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      op_valid = 1'b0;
      err_clr  = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Issue one op for a single cycle; returns at posedge+1.
   task automatic do_op(input logic [2:0] o, input logic [15:0] d);
      op_valid = 1'b1;
      op       = o;
      op_data  = d;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op       = NOP;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < SIZE; i++) ram[i] = 16'hFFFF;
      #2;
      // Reset state (async, before any edge)
      check_eq("rst_ready", op_ready, 1);
      check_eq("rst_depth", depth, 0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_tos", tos, 0);
      check_eq("rst_nos", nos, 0);
      check_eq("rst_flags", {err_ovf, err_unf}, 0);
      do_reset();

      // 1: push three, pop one
      do_op(PUSH, 16'h1111);
      do_op(PUSH, 16'h2222);
      do_op(PUSH, 16'h3333);
      check_eq("t1_depth", depth, 3);
      check_eq("t1_tos", tos, 16'h3333);
      check_eq("t1_nos", nos, 16'h2222);
      do_op(POP, 16'h0);
      check_eq("t1_pop_depth", depth, 2);
      check_eq("t1_pop_tos", tos, 16'h2222);
      check_eq("t1_pop_nos", nos, 16'h1111);

      // 2: SWAP takes two cycles
      do_reset();
      do_op(PUSH, 16'h00AA);
      do_op(PUSH, 16'h00BB);
      do_op(SWAP, 16'h0);
      check_eq("t2_ready_swap2", op_ready, 0);
      step();
      check_eq("t2_ready_after", op_ready, 1);
      check_eq("t2_tos", tos, 16'h00AA);
      check_eq("t2_nos", nos, 16'h00BB);
      check_eq("t2_depth", depth, 2);

      // 3: fill to full, overflow, clear
      do_reset();
      for (int i = 0; i < SIZE; i++) do_op(PUSH, 16'(16'h0100 + i));
      check_eq("t3_full", full, 1);
      check_eq("t3_depth", depth, SIZE);
      check_eq("t3_tos", tos, 16'h013F);
      check_eq("t3_nos", nos, 16'h013E);
      we0 = we_cnt;
      do_op(PUSH, 16'hDEAD);
      check_eq("t3_ovf", err_ovf, 1);
      check_eq("t3_unf_clear", err_unf, 0);
      check_eq("t3_depth_held", depth, SIZE);
      check_eq("t3_no_we", we_cnt - we0, 0);
      check_eq("t3_tos_held", tos, 16'h013F);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_eq("t3_ovf_cleared", err_ovf, 0);
      do_op(DUP, 16'h0);
      check_eq("t3_dup_full_ovf", err_ovf, 1);
      do_op(OVER, 16'h0);
      check_eq("t3_over_full_depth", depth, SIZE);
      check_eq("t3_over_no_we", we_cnt - we0, 0);

      // 4: underflow on POP (empty) and SWAP (depth 1)
      do_reset();
      we0 = we_cnt;
      do_op(POP, 16'h0);
      check_eq("t4_pop_unf", err_unf, 1);
      check_eq("t4_pop_ovf", err_ovf, 0);
      check_eq("t4_pop_depth", depth, 0);
      check_eq("t4_pop_no_we", we_cnt - we0, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_eq("t4_unf_cleared", err_unf, 0);
      do_op(PUSH, 16'h0055);
      we0 = we_cnt;
      do_op(SWAP, 16'h0);
      check_eq("t4_swap_unf", err_unf, 1);
      check_eq("t4_swap_ready", op_ready, 1);
      check_eq("t4_swap_depth", depth, 1);
      check_eq("t4_swap_tos", tos, 16'h0055);
      check_eq("t4_swap_no_we", we_cnt - we0, 0);
      // Error set beats simultaneous clear
      err_clr = 1'b1;
      do_op(POP2PUSH, 16'h0001);
      err_clr = 1'b0;
      check_eq("t4_set_wins", err_unf, 1);
      check_eq("t4_set_wins_depth", depth, 1);

      // 5: POP2PUSH, DUP, OVER, REPLACE
      do_reset();
      do_op(PUSH, 16'h0005);
      do_op(PUSH, 16'h0007);
      do_op(POP2PUSH, 16'h000C);
      check_eq("t5_p2p_depth", depth, 1);
      check_eq("t5_p2p_tos", tos, 16'h000C);
      check_eq("t5_p2p_nos", nos, 0);
      do_op(DUP, 16'h0);
      check_eq("t5_dup_depth", depth, 2);
      check_eq("t5_dup_nos", nos, 16'h000C);
      do_op(PUSH, 16'h0009);
      do_op(POP, 16'h0);
      do_op(OVER, 16'h0);
      check_eq("t5_over_depth", depth, 3);
      check_eq("t5_over_tos", tos, 16'h000C);
      do_op(REPLACE, 16'h0099);
      check_eq("t5_repl_depth", depth, 3);
      check_eq("t5_repl_tos", tos, 16'h0099);
      check_eq("t5_repl_nos", nos, 16'h000C);
      check_eq("t5_no_err", {err_ovf, err_unf}, 0);

      // 6: async reset during SWAP2
      do_reset();
      do_op(POP, 16'h0);
      do_op(PUSH, 16'h0001);
      do_op(PUSH, 16'h0002);
      do_op(SWAP, 16'h0);
      check_eq("t6_in_swap2", op_ready, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("t6_ready", op_ready, 1);
      check_eq("t6_depth", depth, 0);
      check_eq("t6_tos", tos, 0);
      check_eq("t6_flags", {err_ovf, err_unf}, 0);
      step();
      rst_n = 1'b1;
      step();
      check_eq("t6_idle_after", op_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
